// File: rtl/mult16_arb_seq.sv
// Shared radix-4 iterative 16x16 unsigned multiplier with a two-requester round-robin front end.
// Define MULT16_APPROX_EN to truncate the low 8 product columns (approximate build).
module mult16_arb_seq #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_id,
    output logic [31:0] res_p,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [33:0] acc_q, acc_d;
    logic [2:0]  iter_q, iter_d;
    logic        id_q, id_d;
    logic        last_q, last_d;

    logic        grant0, grant1;
    logic [3:0]  shamt;
    logic [1:0]  digit;
    logic [17:0] multiple;
    logic [33:0] pp;
    logic [33:0] accSum;
    logic        unusedAccHi;

    // On a tie the requester not served last wins; last_q resets so RR_INIT wins first.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_q);
        grant1 = req1_valid && (!req0_valid || !last_q);
    end

    assign req0_ready = (state_q == IDLE) && grant0;
    assign req1_ready = (state_q == IDLE) && grant1;

    always_comb begin
        shamt = {iter_q, 1'b0};
        digit = b_q[shamt +: 2];
        case (digit)
            2'd0:    multiple = 18'd0;
            2'd1:    multiple = {2'b00, a_q};
            2'd2:    multiple = {1'b0, a_q, 1'b0};
            default: multiple = {2'b00, a_q} + {1'b0, a_q, 1'b0};
        endcase
        pp = {16'd0, multiple} << shamt;
`ifdef MULT16_APPROX_EN
        accSum = {acc_q[33:8] + pp[33:8], 8'h00};
`else
        accSum = acc_q + pp;
`endif
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        iter_d  = iter_q;
        id_d    = id_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    a_d     = req1_ready ? req1_a : req0_a;
                    b_d     = req1_ready ? req1_b : req0_b;
                    acc_d   = '0;
                    iter_d  = 3'd0;
                    id_d    = req1_ready;
                    last_d  = req1_ready;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d  = accSum;
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            iter_q  <= '0;
            id_q    <= 1'b0;
            last_q  <= ~RR_INIT;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            iter_q  <= iter_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    // The product always fits in 32 bits; the two guard bits never reach the output.
    assign unusedAccHi = ^acc_q[33:32];

    assign res_valid = (state_q == DONE);
    assign res_id    = id_q;
    assign res_p     = acc_q[31:0];
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mult16_arb_seq.sv
// Self-checking bench for mult16_arb_seq: directed steps followed by a randomized soak
// checked against a behavioural product/arbitration model (honours MULT16_APPROX_EN).
module tb_mult16_arb_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        res_valid, res_ready, res_id, busy;
    logic [31:0] res_p;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mult16_arb_seq #(.RR_INIT(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_p      (res_p),
        .busy       (busy)
    );

    // Reference: exact product, or sum of radix-4 partial products with low 8 columns dropped.
    function automatic logic [31:0] refProduct(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] s;
        s = 32'd0;
`ifdef MULT16_APPROX_EN
        for (int i = 0; i < 8; i++) begin
            s = s + (((32'(a) * 32'((b >> (2 * i)) & 16'h0003)) << (2 * i)) & 32'hFFFF_FF00);
        end
`else
        s = 32'(a) * 32'(b);
`endif
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [15:0] a0, input logic [15:0] b0,
                                 input logic v1, input logic [15:0] a1, input logic [15:0] b1,
                                 input logic rr);
        req0_valid = v0;
        req0_a     = a0;
        req0_b     = b0;
        req1_valid = v1;
        req1_a     = a1;
        req1_b     = b1;
        res_ready  = rr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for res_valid after the acceptance edge; returns cycles elapsed.
    task automatic waitResult(output int lat);
        lat = 0;
        while (!res_valid && lat < 30) begin
            tick();
            lat++;
        end
        if (!res_valid) checkOutput("resultTimeout", 32'(res_valid), 32'd1);
    endtask

    // Single operation on one port with res_ready high; checks latency, id, product, return to idle.
    task automatic singleOp(input string tag, input logic id, input logic [15:0] a,
                            input logic [15:0] b, input logic [31:0] expP);
        int lat;
        if (id) applyStimulus(1'b0, 16'd0, 16'd0, 1'b1, a, b, 1'b1);
        else    applyStimulus(1'b1, a, b, 1'b0, 16'd0, 16'd0, 1'b1);
        #1;
        checkOutput({tag, "_ready"}, 32'({req1_ready, req0_ready}), id ? 32'd2 : 32'd1);
        tick();
        applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 1'b1);
        waitResult(lat);
        checkOutput({tag, "_latency"}, 32'(lat), 32'd8);
        checkOutput({tag, "_id"}, 32'(res_id), 32'(id));
        checkOutput({tag, "_p"}, res_p, expP);
        tick();
        checkOutput({tag, "_idle"}, 32'({busy, res_valid}), 32'd0);
    endtask

    logic [32:0] sb[$];
    logic [32:0] expEntry;
    logic [15:0] servedA, servedB;
    logic [31:0] holdP;
    logic        holdId, servedId;
    logic        modelIdle, modelLast, expR0, expR1, hs0, hs1, hsRes;
    int          lat, cnt, done, cyc, sawValid;

    initial begin
        // Reset state
        applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstValid", 32'(res_valid), 32'd0);
        checkOutput("rstP", res_p, 32'd0);
        checkOutput("rstId", 32'(res_id), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Arbitration: both valid continuously, RR_INIT=1 -> ids 1,0,1,0
        applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b1, 16'($urandom), 16'($urandom), 1'b1);
        for (int k = 0; k < 4; k++) begin
            #1;
            servedId = (k % 2 == 0);
            checkOutput("arbReady", 32'({req1_ready, req0_ready}), servedId ? 32'd2 : 32'd1);
            servedA = servedId ? req1_a : req0_a;
            servedB = servedId ? req1_b : req0_b;
            tick();
            if (servedId) begin
                req1_a = 16'($urandom);
                req1_b = 16'($urandom);
            end else begin
                req0_a = 16'($urandom);
                req0_b = 16'($urandom);
            end
            waitResult(lat);
            checkOutput("arbLatency", 32'(lat), 32'd8);
            checkOutput("arbId", 32'(res_id), 32'(servedId));
            checkOutput("arbP", res_p, refProduct(servedA, servedB));
            tick();
            checkOutput("arbIdle", 32'(busy), 32'd0);
        end
        applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 1'b1);
        tick();

        // Directed products
`ifdef MULT16_APPROX_EN
        singleOp("maxOp", 1'b0, 16'hFFFF, 16'hFFFF, refProduct(16'hFFFF, 16'hFFFF));
        singleOp("ffOp", 1'b1, 16'h00FF, 16'h00FF, 32'h0000_FB00);
        singleOp("smallOp", 1'b0, 16'd3, 16'd5, 32'd0);
`else
        singleOp("maxOp", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
        singleOp("ffOp", 1'b1, 16'h00FF, 16'h00FF, 32'h0000_FE01);
        singleOp("smallOp", 1'b0, 16'd3, 16'd5, 32'd15);
`endif

        // Backpressure: 20 cycles stalled in DONE with both requesters waiting
        applyStimulus(1'b0, 16'd0, 16'd0, 1'b1, 16'hBEEF, 16'h0F0F, 1'b0);
        tick();
        applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 1'b0);
        waitResult(lat);
        holdP  = res_p;
        holdId = res_id;
        checkOutput("bpP", holdP, refProduct(16'hBEEF, 16'h0F0F));
        applyStimulus(1'b1, 16'h1111, 16'h2222, 1'b1, 16'h3333, 16'h4444, 1'b0);
        for (int k = 0; k < 20; k++) begin
            tick();
            #1;
            checkOutput("bpHoldValid", 32'(res_valid), 32'd1);
            checkOutput("bpHoldP", res_p, holdP);
            checkOutput("bpHoldId", 32'(res_id), 32'(holdId));
            checkOutput("bpReadys", 32'({req1_ready, req0_ready}), 32'd0);
        end
        res_ready = 1'b1;
        tick();
        checkOutput("bpRelease", 32'({busy, res_valid}), 32'd0);
        applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 1'b1);
        tick();

        // Reset during RUN at iteration 4
        applyStimulus(1'b0, 16'd0, 16'd0, 1'b1, 16'hABCD, 16'h1357, 1'b1);
        tick();
        applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 1'b1);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midRstOut", 32'({res_valid, res_id, busy}), 32'd0);
        checkOutput("midRstP", res_p, 32'd0);
        tick();
        rst_n = 1'b1;
        sawValid = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (res_valid) sawValid++;
        end
        checkOutput("midRstStale", 32'(sawValid), 32'd0);
`ifdef MULT16_APPROX_EN
        singleOp("postRstOp", 1'b0, 16'h1234, 16'h0010, 32'h0001_2300);
`else
        singleOp("postRstOp", 1'b0, 16'h1234, 16'h0010, 32'h0001_2340);
`endif

        // Random soak against the behavioural model
        modelIdle = 1'b1;
        modelLast = 1'b0;
        cnt  = 0;
        done = 0;
        cyc  = 0;
        applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 1'b0);
        while (done < 300 && cyc < 20000) begin
            if (!req0_valid && $urandom_range(1, 0) == 1) begin
                req0_valid = 1'b1;
                req0_a = 16'($urandom);
                req0_b = 16'($urandom);
            end
            if (!req1_valid && $urandom_range(1, 0) == 1) begin
                req1_valid = 1'b1;
                req1_a = 16'($urandom);
                req1_b = 16'($urandom);
            end
            res_ready = ($urandom_range(3, 0) != 0);
            #1;
            expR0 = modelIdle && req0_valid && (!req1_valid || modelLast);
            expR1 = modelIdle && req1_valid && (!req0_valid || !modelLast);
            checkOutput("soakReady", 32'({req1_ready, req0_ready}), 32'({expR1, expR0}));
            checkOutput("soakValid", 32'(res_valid), 32'(!modelIdle && cnt >= 8));
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("soakSpurious", 32'(res_valid), 32'd0);
                end else begin
                    expEntry = sb.pop_front();
                    checkOutput("soakId", 32'(res_id), 32'(expEntry[32]));
                    checkOutput("soakP", res_p, expEntry[31:0]);
                end
                done++;
            end
            hs0   = req0_valid && req0_ready;
            hs1   = req1_valid && req1_ready;
            hsRes = res_valid && res_ready;
            tick();
            cyc++;
            if (hs0) begin
                sb.push_back({1'b0, refProduct(req0_a, req0_b)});
                modelLast  = 1'b0;
                modelIdle  = 1'b0;
                cnt        = 0;
                req0_valid = 1'b0;
            end else if (hs1) begin
                sb.push_back({1'b1, refProduct(req1_a, req1_b)});
                modelLast  = 1'b1;
                modelIdle  = 1'b0;
                cnt        = 0;
                req1_valid = 1'b0;
            end else if (!modelIdle) begin
                if (hsRes) modelIdle = 1'b1;
                else if (cnt < 8) cnt++;
            end
        end
        checkOutput("soakDone", 32'(done), 32'd300);
        checkOutput("soakLeft", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
